// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: fetch PC, ROM addressing, prefetch FIFO and decode handshake.
// Optional out-of-window fetch trap enabled by defining FETCH_BOUND_CHECK_EN.
module instr_fetch_ctrl #(
   parameter int unsigned  A_LEN    = 12,
   parameter int unsigned  DEPTH    = 4,
   parameter logic [31:0]  RESET_PC = 32'hBFC00000
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [A_LEN-1:0] mem_addr,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      instr,
   output logic [31:0]      instr_pc,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic             fetch_fault
);
   localparam int unsigned   PW      = $clog2(DEPTH);
   localparam int unsigned   CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {RUN, FULL, FAULT} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic [31:0]   pcs_q  [DEPTH];
   logic [31:0]   pcs_d  [DEPTH];
   logic          pop, push, out_of_window;

`ifdef FETCH_BOUND_CHECK_EN
   assign out_of_window = (fetch_pc_q[31:A_LEN] != RESET_PC[31:A_LEN]);
`else
   assign out_of_window = 1'b0;
`endif

   assign mem_addr = fetch_pc_q[A_LEN-1:0];
   assign pop      = instr_valid & instr_ready & ~redirect_valid;
   // FULL may still push when the head leaves in the same cycle.
   assign push     = (state_q != FAULT) & ~redirect_valid & ~out_of_window &
                     ((count_q < DEPTH_C) | pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            pcs_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         data_q     <= data_d;
         pcs_q      <= pcs_d;
      end
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      data_d     = data_q;
      pcs_d      = pcs_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~32'h3;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (push) begin
            data_d[wr_ptr_q] = mem_rdata;
            pcs_d[wr_ptr_q]  = fetch_pc_q;
            wr_ptr_d         = wr_ptr_q + PW'(1);
            fetch_pc_d       = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = RUN;
      end else if (state_q == FAULT || out_of_window) begin
         state_d = FAULT;
      end else if (count_d == DEPTH_C && !pop) begin
         state_d = FULL;
      end else begin
         state_d = RUN;
      end
   end

   always_comb begin
      instr_valid = (count_q != '0);
      instr       = data_q[rd_ptr_q];
      instr_pc    = pcs_q[rd_ptr_q];
`ifdef FETCH_BOUND_CHECK_EN
      fetch_fault = (state_q == FAULT);
`else
      fetch_fault = 1'b0;
`endif
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Table-driven bench for instr_fetch_ctrl against a combinational ROM whose word encodes its address.
// Expectations follow FETCH_BOUND_CHECK_EN when the build defines it.
module tb_instr_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   always #5 clk = ~clk;

   instr_fetch_ctrl #(
      .A_LEN   (12),
      .DEPTH   (4),
      .RESET_PC(32'hBFC00000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .fetch_fault   (fetch_fault)
   );

   assign mem_rdata = {20'hC0DE0, mem_addr};

   function automatic logic [31:0] rom_word(input logic [31:0] pc);
      return {20'hC0DE0, pc[11:0]};
   endfunction

   typedef struct {
      logic        rst_n;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        chk;
      logic        ev;
      logic [31:0] ep;
      logic [11:0] ea;
      logic        ef;
   } vec_t;

   vec_t vq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic chk, input logic ev, input logic [31:0] ep,
                      input logic [11:0] ea, input logic ef);
      vec_t v;
      v.rst_n = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.chk = chk; v.ev = ev; v.ep = ep; v.ea = ea; v.ef = ef;
      vq.push_back(v);
   endtask

   initial begin
      int cycles;
      localparam logic [31:0] B = 32'hBFC00000;

      // streaming from reset
      add(0, 1, 0, 0, 0, 0, 0,        12'h000, 0);
      add(1, 1, 0, 0, 1, 0, 0,        12'h000, 0);
      add(1, 1, 0, 0, 1, 1, B,        12'h004, 0);
      add(1, 1, 0, 0, 1, 1, B+4,      12'h008, 0);
      add(1, 1, 0, 0, 1, 1, B+8,      12'h00C, 0);
      // decode stalled: exactly four pushes, then drain without gap
      add(0, 0, 0, 0, 0, 0, 0,        12'h000, 0);
      add(1, 0, 0, 0, 1, 0, 0,        12'h000, 0);
      add(1, 0, 0, 0, 1, 1, B,        12'h004, 0);
      add(1, 0, 0, 0, 1, 1, B,        12'h008, 0);
      add(1, 0, 0, 0, 1, 1, B,        12'h00C, 0);
      for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 1, 1, B, 12'h010, 0);
      add(1, 1, 0, 0, 1, 1, B,        12'h010, 0);
      add(1, 1, 0, 0, 1, 1, B+4,      12'h014, 0);
      add(1, 1, 0, 0, 1, 1, B+8,      12'h018, 0);
      add(1, 1, 0, 0, 1, 1, B+12,     12'h01C, 0);
      add(1, 1, 0, 0, 1, 1, B+16,     12'h020, 0);
      // redirect on a full FIFO, misaligned target
      add(1, 1, 1, 32'hBFC00103, 1, 1, B+20, 12'h024, 0);
      add(1, 1, 0, 0, 1, 0, 0,        12'h100, 0);
      add(1, 1, 0, 0, 1, 1, B+32'h100, 12'h104, 0);
      // back-to-back redirects
      add(1, 1, 1, 32'hBFC00200, 1, 1, B+32'h104, 12'h108, 0);
      add(1, 1, 1, 32'hBFC00300, 1, 0, 0, 12'h200, 0);
      add(1, 1, 0, 0, 1, 0, 0,        12'h300, 0);
      add(1, 1, 0, 0, 1, 1, B+32'h300, 12'h304, 0);
      add(1, 1, 0, 0, 1, 1, B+32'h304, 12'h308, 0);
      // reset with three entries buffered
      add(1, 0, 0, 0, 1, 1, B+32'h308, 12'h30C, 0);
      add(1, 0, 0, 0, 1, 1, B+32'h308, 12'h310, 0);
      add(0, 1, 0, 0, 0, 0, 0,        12'h000, 0);
      add(1, 1, 0, 0, 1, 0, 0,        12'h000, 0);
      add(1, 1, 0, 0, 1, 1, B,        12'h004, 0);
      // fetch across the top of the window
      add(1, 1, 1, 32'hBFC00FFC, 1, 1, B+4, 12'h008, 0);
      add(1, 1, 0, 0, 1, 0, 0,        12'hFFC, 0);
`ifdef FETCH_BOUND_CHECK_EN
      add(1, 1, 0, 0, 1, 1, B+32'hFFC, 12'h000, 0);
      add(1, 1, 0, 0, 1, 0, 0,        12'h000, 1);
      add(1, 1, 1, B, 1, 0, 0,        12'h000, 1);
      add(1, 1, 0, 0, 1, 0, 0,        12'h000, 0);
      add(1, 1, 0, 0, 1, 1, B,        12'h004, 0);
`else
      add(1, 1, 0, 0, 1, 1, B+32'hFFC,  12'h000, 0);
      add(1, 1, 0, 0, 1, 1, 32'hBFC01000, 12'h004, 0);
      add(1, 1, 1, B, 1, 1, 32'hBFC01004, 12'h008, 0);
      add(1, 1, 0, 0, 1, 0, 0,        12'h000, 0);
      add(1, 1, 0, 0, 1, 1, B,        12'h004, 0);
`endif

      rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      cmp("reset valid", {31'b0, instr_valid}, 32'd0);
      cmp("reset instr", instr, 32'd0);
      cmp("reset instr_pc", instr_pc, 32'd0);
      cmp("reset fault", {31'b0, fetch_fault}, 32'd0);
      cmp("reset addr", {20'b0, mem_addr}, 32'd0);

      for (int i = 0; i < vq.size(); i++) begin
         rst_n          = vq[i].rst_n;
         instr_ready    = vq[i].rdy;
         redirect_valid = vq[i].rv;
         redirect_pc    = vq[i].rpc;
         if (vq[i].chk) begin
            cmp($sformatf("row%0d valid", i), {31'b0, instr_valid}, {31'b0, vq[i].ev});
            cmp($sformatf("row%0d addr", i), {20'b0, mem_addr}, {20'b0, vq[i].ea});
            cmp($sformatf("row%0d fault", i), {31'b0, fetch_fault}, {31'b0, vq[i].ef});
            if (vq[i].ev) begin
               cmp($sformatf("row%0d instr_pc", i), instr_pc, vq[i].ep);
               cmp($sformatf("row%0d instr", i), instr, rom_word(vq[i].ep));
            end
         end
         @(posedge clk);
         #1;
      end

      // redirect while decode stalls: first word must surface one cycle after the redirect edge
      instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hBFC00043;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0; redirect_pc = '0;
      cycles = 0;
      while (!instr_valid && cycles < 4) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      if (!instr_valid) begin
         total++; bad++;
         $display("FAIL redirect wait timeout actual=no_valid required=valid");
      end else begin
         cmp("redirect latency", cycles, 32'd1);
         cmp("redirect instr_pc", instr_pc, 32'hBFC00040);
         cmp("redirect instr", instr, rom_word(32'hBFC00040));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
